// File: rtl/sigbuff_ctrl_if.sv
// Handshake/bus bundle between the iteration controller and the signal buffer.
// master: controller side (drives write/read requests, consumes samples).
// slave : buffer side.
interface sigbuff_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  // iteration tag and path control
  logic [4:0]        iter_num;
  logic              input_mux;
  logic              input_enable;
  logic              output_enable;

  // write sources
  logic [DATA_W-1:0] lvl_data;
  logic              lvl_valid;
  logic [DATA_W-1:0] lim_data;
  logic              lim_valid;

  // read side towards the FIR front end
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_iter;
  logic              out_valid;
  logic              out_ready;

  // status
  logic              iter_done;
  logic [ADDR_W:0]   fill_level;
  logic              overflow;

  modport master (
    output iter_num, input_mux, input_enable, output_enable,
    output lvl_data, lvl_valid, lim_data, lim_valid,
    output out_ready,
    input  out_data, out_iter, out_valid,
    input  iter_done, fill_level, overflow
  );

  modport slave (
    input  iter_num, input_mux, input_enable, output_enable,
    input  lvl_data, lvl_valid, lim_data, lim_valid,
    input  out_ready,
    output out_data, out_iter, out_valid,
    output iter_done, fill_level, overflow
  );
endinterface

// File: rtl/sigbuff_ctrl.sv
// Signal buffer controller: circular sample store for iterative reconstruction.
// Written by the level generator (first pass) or the hard limiter (feedback
// passes), read by the FIR front end, with fill/overflow/iteration status.
//
// Read-side FSM
//   state   | meaning
//   RD_IDLE | no read in flight; a read may issue this cycle
//   RD_PEND | read issued last edge, its sample is now on out_data; no issue
//
// The RAM read register doubles as the out_data register: an issue loads it
// at the same edge that raises out_valid, so issue-to-valid latency is one
// cycle, and the RD_PEND cycle that follows limits throughput to one sample
// every two cycles.
module sigbuff_ctrl #(
  parameter int MAX_SAMPLES_IN_RAM = 255,
  parameter int DATA_W             = 16,
  parameter int ADDR_W             = 8
) (
  input  logic           clock,
  input  logic           reset,
  sigbuff_ctrl_if.slave  bus
);

  localparam int               CNT_W    = ADDR_W + 1;
  localparam int               RAM_D    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_SAMPLES_IN_RAM - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(MAX_SAMPLES_IN_RAM);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PEND = 1'b1
  } rd_state_t;

  rd_state_t         rd_state_q, rd_state_d;

  logic [DATA_W-1:0] mem_q [RAM_D];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              iter_done_q, iter_done_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [4:0]        out_iter_q, out_iter_d;
  logic              out_valid_q, out_valid_d;

  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              wr_req;
  logic              wr_accept;
  logic              rd_issue;

  // Write source select is purely combinational; whichever source is
  // selected this cycle is the one that can write.
  assign sel_valid = bus.input_mux ? bus.lim_valid : bus.lvl_valid;
  assign sel_data  = bus.input_mux ? bus.lim_data  : bus.lvl_data;
  assign wr_req    = bus.input_enable & sel_valid;

  // A full buffer still takes a write when a read frees a slot the same cycle.
  assign wr_accept = wr_req & ((count_q < FULL_CNT) | rd_issue);

  // Read FSM next state and read-issue decision.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_issue   = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (bus.output_enable && (count_q != '0) &&
            (!out_valid_q || bus.out_ready)) begin
          rd_issue   = 1'b1;
          rd_state_d = RD_PEND;
        end
      end
      RD_PEND: begin
        rd_state_d = RD_IDLE;
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  // Pointer, occupancy, overflow and wrap-pulse next-state logic.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    iter_done_d = 1'b0;

    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + ADDR_W'(1);
    end

    if (rd_issue) begin
      rd_ptr_d    = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + ADDR_W'(1);
      iter_done_d = (rd_ptr_q == LAST_IDX);
    end

    case ({wr_accept, rd_issue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_req && !wr_accept) begin
      overflow_d = 1'b1;
    end
  end

  // Control/status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      iter_done_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      iter_done_q <= iter_done_d;
    end
  end

  // Sample store; contents survive reset, count=0 makes them unreachable.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= sel_data;
    end
  end

  // Output stage next state: load on issue, hold while stalled, drop valid
  // once consumed with nothing new landing.
  always_comb begin
    out_data_d  = out_data_q;
    out_iter_d  = out_iter_q;
    out_valid_d = out_valid_q;
    if (rd_issue) begin
      out_data_d  = mem_q[rd_ptr_q];
      out_iter_d  = bus.iter_num;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage registers; reset discards any sample in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q  <= '0;
      out_iter_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_iter_q  <= out_iter_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_iter   = out_iter_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.iter_done  = iter_done_q;
  assign bus.fill_level = count_q;
  assign bus.overflow   = overflow_q;

endmodule
